data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//   Shares the byte-wide 512-byte data memory between two 16-bit word requesters:
//   port 0 (CPU load/store unit) and port 1 (loader/debug DMA).
//   Round-robin arbitration. Each word access runs as two byte accesses:
//   high byte at 2*addr, then low byte at 2*addr+1 (big-endian).
//   Returns the assembled word with a one-cycle ack. Sits between the MEM stage and the memory array.
// PARAMETERS
//   ADDR_W   8   word-address bits actually decoded (2**ADDR_W words = 512 bytes)
// PORTS
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   m0_req     in   1       port 0 request; held high until m0_ack
//   m0_we      in   1       port 0: 1 = store, 0 = load
//   m0_addr    in   16      port 0 word address
//   m0_wdata   in   16      port 0 store data
//   m0_ack     out  1       port 0 one-cycle completion pulse
//   m0_err     out  1       valid with m0_ack: address out of range
//   m1_req/m1_we/m1_addr/m1_wdata/m1_ack/m1_err: same as port 0, for port 1
//   rdata      out  16      load data; valid in the cycle of either ack
//   mem_addr   out  ADDR_W+1  byte address to the memory array
//   mem_we     out  1       byte write strobe (array writes on clk rising edge)
//   mem_wdata  out  8       byte write data
//   mem_rdata  in   8       byte read data; combinational from mem_addr
//   busy       out  1       1 in any state other than IDLE
// BEHAVIOUR
//   FSM states: IDLE, HI, LO, RESP. Reset enters IDLE.
//   Reset values: all acks, errs and mem_we = 0; rdata = 0; mem_addr = 0; mem_wdata = 0.
//     Internal latch registers = 0; last_gnt = 1, so port 0 wins the first tie.
//   IDLE: if any req is high, grant one port and go to HI.
//     Grant rule: a single requester wins outright. On a tie, the port != last_gnt wins.
//     On grant, latch we, addr and wdata, and set last_gnt to the granted port.
//   Range check: out of range when latched addr[15:ADDR_W] != 0.
//     HI and LO then drive mem_we = 0 and capture nothing.
//     RESP then gives err = 1 and rdata = 0.
//   HI: mem_addr = {addr[ADDR_W-1:0],1'b0}.
//     Store: mem_we = 1, mem_wdata = wdata[15:8].
//     Load: capture mem_rdata into rdata[15:8] at the clock edge. Go to LO.
//   LO: mem_addr = {addr[ADDR_W-1:0],1'b1}.
//     Store: mem_we = 1, mem_wdata = wdata[7:0].
//     Load: capture into rdata[7:0]. Go to RESP.
//   RESP: granted port's ack = 1 for exactly this cycle, with err valid.
//     rdata holds the load word (stores leave rdata unchanged). Go to IDLE.
//   Latency: req high in IDLE at cycle t -> ack in cycle t+3. Throughput: one word per 4 cycles.
//   Requester must drop req in the cycle after ack, or it is re-arbitrated as a new request.
//   Request inputs are ignored outside IDLE. Latched values are immune to input changes mid-access.
//   mem_we is 0 in IDLE and RESP; writes only in HI/LO of an in-range store.
//   rst mid-access: FSM goes to IDLE at once, mem_we drops, no ack is issued.
//     The memory may hold a half-written word (high byte only); this is accepted.
//   Both ports may target the same address back-to-back. Accesses are strictly serialised
//     in grant order, so a load after a store returns the stored word.
// TESTING
//   Store then load: m0 store addr 0x0005 data 0xBEEF, then m0 load 0x0005.
//     -> bytes 10 = 0xBE and 11 = 0xEF; load rdata = 0xBEEF, ack 3 cycles after req.
//   Tie after reset: m0_req and m1_req rise together.
//     -> m0 acked first; m1 acked 4 cycles later; next tie grants m0.
//   Fairness: m1 held continuously, m0 re-requests after each ack.
//     -> acks alternate m0, m1, m0, m1; neither port is served twice in a row while the other waits.
//   Out of range: load addr 0x0100 (ADDR_W = 8). -> ack with err = 1, rdata = 0, mem_we never high.
//   Reset during HI of a store to 0x0002, data 0x1234.
//     -> no ack; busy = 0 and mem_we = 0 immediately; byte 4 = 0x12, byte 5 unchanged.
//   Boundary: store 0x00FF data 0xA55A, then load it.
//     -> byte addresses 510 and 511 are used; rdata = 0xA55A, no wrap to byte 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a byte-wide data memory between two 16-bit word requesters.
// Each word access is split into a big-endian high-byte then low-byte memory cycle.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [15:0]       m0_addr,
  input  logic [15:0]       m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [15:0]       m1_addr,
  input  logic [15:0]       m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [15:0]       rdata,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StHi, StLo, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_gnt_q;
  logic        gnt_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;

  logic        any_req;
  logic        gnt_d;
  logic        in_range;
  logic        wr_en;

  assign any_req  = m0_req | m1_req;
  // On a tie the port that was not served last wins; otherwise the lone requester.
  assign gnt_d    = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
  assign in_range = (addr_q[15:ADDR_W] == '0);
  assign wr_en    = we_q & in_range;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StHi;
      StHi:    state_d = StLo;
      StLo:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Grant bookkeeping, request latches and load-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (state_q == StIdle && any_req) begin
        gnt_q      <= gnt_d;
        last_gnt_q <= gnt_d;
        we_q       <= gnt_d ? m1_we    : m0_we;
        addr_q     <= gnt_d ? m1_addr  : m0_addr;
        wdata_q    <= gnt_d ? m1_wdata : m0_wdata;
      end
      if (state_q == StHi && !we_q && in_range) begin
        rdata_q[15:8] <= mem_rdata;
      end
      if (state_q == StLo && !we_q && in_range) begin
        rdata_q[7:0] <= mem_rdata;
      end
    end
  end

  // Output logic
  always_comb begin
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    rdata     = rdata_q;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StHi: begin
        mem_addr  = {addr_q[ADDR_W-1:0], 1'b0};
        mem_we    = wr_en;
        mem_wdata = wr_en ? wdata_q[15:8] : 8'h00;
      end
      StLo: begin
        mem_addr  = {addr_q[ADDR_W-1:0], 1'b1};
        mem_we    = wr_en;
        mem_wdata = wr_en ? wdata_q[7:0] : 8'h00;
      end
      StResp: begin
        m0_ack = ~gnt_q;
        m1_ack = gnt_q;
        m0_err = ~gnt_q & ~in_range;
        m1_err = gnt_q & ~in_range;
        // A rejected access reports zero without disturbing the held load word.
        if (!in_range) rdata = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: vector table, directed corner sequences and a
// randomized two-port run checked against a transaction-level timeline model.
module tb_data_mem_arbiter;
  localparam int unsigned ADDR_W = 8;
  localparam int NRAND = 3000;

  logic              clk, rst;
  logic              m0_req, m0_we, m0_ack, m0_err;
  logic              m1_req, m1_we, m1_ack, m1_err;
  logic [15:0]       m0_addr, m0_wdata, m1_addr, m1_wdata, rdata;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_we, busy;
  logic [7:0]        mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Byte memory array with a bench-side preload/clear port.
  logic [7:0] mem [512];
  logic       clr, pre_we;
  logic [8:0] pre_addr;
  logic [7:0] pre_data;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    m0_req = 1'b0;
    m1_req = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
  endtask

  // One word access on one port; returns ack latency (-1 on timeout).
  task automatic do_access(input bit port, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, output bit err,
                           output logic [15:0] rd, output int lat, output bit saw_we);
    err = 1'b0; rd = '0; lat = -1; saw_we = 1'b0;
    @(posedge clk); #1;
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_we) saw_we = 1'b1;
      if (port ? m1_ack : m0_ack) begin
        lat = k;
        err = port ? m1_err : m0_err;
        rd  = rdata;
        break;
      end
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    check("ack_pulse", 32'({m0_ack, m1_ack}), 32'(0));
  endtask

  // Both ports load at once; each drops its request the cycle after its ack.
  task automatic run_both(output int a0, output int a1,
                          output logic [15:0] r0, output logic [15:0] r1);
    logic d0, d1;
    a0 = -1; a1 = -1; r0 = '0; r1 = '0;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0005;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h00FF;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      d0 = m0_ack;
      d1 = m1_ack;
      if (d0 && a0 < 0) begin a0 = k; r0 = rdata; end
      if (d1 && a1 < 0) begin a1 = k; r1 = rdata; end
      @(posedge clk); #1;
      if (d0) m0_req = 1'b0;
      if (d1) m1_req = 1'b0;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          err;
    logic [15:0] rdata;
  } vec_t;

  vec_t        vt [8];
  bit          v_err, v_saw;
  logic [15:0] v_rd, r0, r1;
  int          v_lat, a0, a1;
  int          order [6];
  int          nacks;
  bit          wait0, d0, d1, saw_ack;

  // Reference model state for the random run
  logic [15:0] ref_mem [256];
  logic [15:0] last_load, exp_rd;
  bit          last_gnt, pend, exp_port, exp_err, gp, gwe;
  int          free_at, ack_cyc;
  logic [15:0] ga, gwd;

  initial begin
    rst = 1'b1; clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("reset_ctl", 32'({m0_ack, m0_err, m1_ack, m1_err, mem_we, busy}), 32'(0));
    check("reset_rdata", 32'(rdata), 32'(0));
    check("reset_mem_addr", 32'(mem_addr), 32'(0));
    check("reset_mem_wdata", 32'(mem_wdata), 32'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Single-port accesses; stores report the previous load word on rdata.
    vt[0] = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0000};
    vt[1] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF};
    vt[2] = '{1'b0, 1'b1, 16'h00FF, 16'hA55A, 1'b0, 16'hBEEF};
    vt[3] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 1'b0, 16'hA55A};
    vt[4] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000};
    vt[5] = '{1'b0, 1'b1, 16'h8000, 16'h1357, 1'b1, 16'h0000};
    vt[6] = '{1'b1, 1'b1, 16'h0010, 16'h0102, 1'b0, 16'hA55A};
    vt[7] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF};
    for (int i = 0; i < 8; i++) begin
      do_access(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, v_err, v_rd, v_lat, v_saw);
      check($sformatf("vec%0d_latency", i), 32'(v_lat), 32'(3));
      check($sformatf("vec%0d_err", i), 32'(v_err), 32'(vt[i].err));
      check($sformatf("vec%0d_rdata", i), 32'(v_rd), 32'(vt[i].rdata));
      check($sformatf("vec%0d_mem_we", i), 32'(v_saw), 32'(vt[i].we && !vt[i].err));
    end
    check("byte10", 32'(mem[10]), 32'(8'hBE));
    check("byte11", 32'(mem[11]), 32'(8'hEF));
    check("byte510", 32'(mem[510]), 32'(8'hA5));
    check("byte511", 32'(mem[511]), 32'(8'h5A));
    check("byte0_no_wrap", 32'({mem[0], mem[1]}), 32'(0));
    check("byte32_33", 32'({mem[32], mem[33]}), 32'(16'h0102));

    // Ties after reset: m0 first, m1 four cycles later, and the next tie again favours m0.
    apply_reset();
    run_both(a0, a1, r0, r1);
    check("tie1_m0_cycle", 32'(a0), 32'(3));
    check("tie1_m1_cycle", 32'(a1), 32'(7));
    check("tie1_m0_rdata", 32'(r0), 32'(16'hBEEF));
    check("tie1_m1_rdata", 32'(r1), 32'(16'hA55A));
    run_both(a0, a1, r0, r1);
    check("tie2_m0_cycle", 32'(a0), 32'(3));
    check("tie2_m1_cycle", 32'(a1), 32'(7));

    // Fairness: m1 never drops, m0 re-requests one cycle after each ack.
    apply_reset();
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0005;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h00FF;
    nacks = 0; wait0 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      d0 = m0_ack;
      d1 = m1_ack;
      if (d0 || d1) begin
        if (nacks < 6) order[nacks] = 32'(d1);
        nacks++;
      end
      @(posedge clk); #1;
      if (d0) begin
        m0_req = 1'b0; wait0 = 1'b1;
      end else if (wait0) begin
        m0_req = 1'b1; wait0 = 1'b0;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("fair_ack_count", 32'(nacks), 32'(10));
    for (int i = 0; i < 6; i++) check($sformatf("fair_order%0d", i), 32'(order[i]), 32'(i % 2));

    // Reset once the high byte of a store has landed: no ack, low byte untouched.
    apply_reset();
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = 9'd5; pre_data = 8'h77;
    @(posedge clk); #1;
    pre_we = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0002; m0_wdata = 16'h1234;
    @(posedge clk); #1;
    check("rst_hi_mem_we", 32'(mem_we), 32'(1));
    check("rst_hi_mem_addr", 32'(mem_addr), 32'(4));
    @(posedge clk); #1;
    m0_req = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    saw_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m0_ack || m1_ack) saw_ack = 1'b1;
    end
    check("rst_no_ack", 32'(saw_ack), 32'(0));
    check("rst_byte4", 32'(mem[4]), 32'(8'h12));
    check("rst_byte5", 32'(mem[5]), 32'(8'h77));

    // Random two-port traffic against a word-level timeline model.
    apply_reset();
    for (int w = 0; w < 256; w++) ref_mem[w] = {mem[2*w], mem[2*w+1]};
    last_gnt = 1'b1; pend = 1'b0; free_at = 0; ack_cyc = 0; last_load = '0;
    exp_port = 1'b0; exp_err = 1'b0; exp_rd = '0;
    for (int n = 0; n < NRAND; n++) begin
      @(negedge clk);
      check("rnd_ack0", 32'(m0_ack), 32'(pend && n == ack_cyc && !exp_port));
      check("rnd_ack1", 32'(m1_ack), 32'(pend && n == ack_cyc && exp_port));
      if (pend && n == ack_cyc) begin
        check("rnd_err", 32'(exp_port ? m1_err : m0_err), 32'(exp_err));
        check("rnd_rdata", 32'(rdata), 32'(exp_rd));
        pend = 1'b0;
      end
      if (n >= free_at && (m0_req || m1_req)) begin
        if (m0_req && m1_req) gp = !last_gnt;
        else if (m0_req)      gp = 1'b0;
        else                  gp = 1'b1;
        last_gnt = gp;
        gwe = gp ? m1_we : m0_we;
        ga  = gp ? m1_addr : m0_addr;
        gwd = gp ? m1_wdata : m0_wdata;
        exp_err = (int'(ga) >= 256);
        if (exp_err) begin
          exp_rd = '0;
        end else if (gwe) begin
          ref_mem[ga[7:0]] = gwd;
          exp_rd = last_load;
        end else begin
          last_load = ref_mem[ga[7:0]];
          exp_rd = last_load;
        end
        exp_port = gp;
        ack_cyc  = n + 3;
        free_at  = n + 4;
        pend     = 1'b1;
      end
      d0 = m0_ack;
      d1 = m1_ack;
      @(posedge clk); #1;
      if (d0) begin
        m0_req = 1'b0;
      end else if (!m0_req && $urandom_range(0, 2) == 0) begin
        m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1)); m0_wdata = 16'($urandom);
        m0_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      end
      if (d1) begin
        m1_req = 1'b0;
      end else if (!m1_req && $urandom_range(0, 2) == 0) begin
        m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1)); m1_wdata = 16'($urandom);
        m1_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
